spi_txn_arbiter: RTL and testbench

Shares the single SPI master among four requesters, one per chip-select device. It drives the SPI master's Avalon-MM slave port as a bus master. Per granted transaction it programs BRD and CTRL, pushes one word into the TX FIFO, then polls STATUS until the word has fully shifted out before acknowledging. Arbitration is round-robin, so no requester starves.

---
 rtl/spi_txn_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI master among four requesters.
// It programs the master over Avalon-MM, pushes one word, and polls until the word has shifted out.
module spi_txn_arbiter #(
    parameter int unsigned POLL_TIMEOUT   = 65535,
    parameter int unsigned CS_IDLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [127:0] req_data,
    input  logic [19:0]  req_size,
    input  logic [7:0]   mode_cfg,
    input  logic [31:0]  brd_cfg,
    input  logic         spi_cs_idle,
    output logic [1:0]   av_address,
    output logic         av_write,
    output logic         av_read,
    output logic [31:0]  av_writedata,
    input  logic [31:0]  av_readdata,
    input  logic         av_waitrequest,
    output logic [3:0]   ack,
    output logic [3:0]   err,
    output logic         busy,
    output logic [1:0]   grant
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(POLL_TIMEOUT);
    localparam logic [CNT_W-1:0] IDLE_REQ = CNT_W'(CS_IDLE_CYCLES);
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_BRD    = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_BRD, S_WR_CTRL, S_WR_DATA, S_POLL, S_WAIT_CS, S_CLR_OV, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d, rr_q, rr_d;
    logic [31:0]      data_q, data_d;
    logic [4:0]       size_q, size_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d, idle_cnt_q, idle_cnt_d;
    logic [1:0]       av_address_q, av_address_d;
    logic             av_write_q, av_write_d, av_read_q, av_read_d;
    logic [31:0]      av_writedata_q, av_writedata_d;
    logic [3:0]       ack_q, ack_d, err_q, err_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [1:0]       pick, idx;
    logic [3:0]       grant_oh;
    logic [31:0]      ctrl_word;
    logic [CNT_W-1:0] poll_inc, idle_inc;
    logic             unused_rdata;

    assign unused_rdata = ^{av_readdata[31:6], av_readdata[4], av_readdata[2:0]};
    assign grant_oh  = 4'b0001 << grant_q;
    assign ctrl_word = {14'h0000, mode_q, 1'b1, grant_q, 4'b0000, grant_oh, size_q};
    assign poll_inc  = (poll_cnt_q == CNT_MAX) ? CNT_MAX : poll_cnt_q + CNT_W'(1);
    assign idle_inc  = (idle_cnt_q == CNT_MAX) ? CNT_MAX : idle_cnt_q + CNT_W'(1);

    // Next-state and registered-output logic; each command holds until waitrequest drops.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_d           = rr_q;
        data_d         = data_q;
        size_d         = size_q;
        mode_d         = mode_q;
        poll_cnt_d     = poll_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        av_address_d   = av_address_q;
        av_writedata_d = av_writedata_q;
        av_write_d     = 1'b0;
        av_read_d      = 1'b0;
        ack_d          = 4'b0000;
        err_d          = 4'b0000;
        found          = 1'b0;
        pick           = rr_q;
        idx            = 2'd0;

        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d        = S_WR_BRD;
                    grant_d        = pick;
                    data_d         = req_data[{pick, 5'b00000} +: 32];
                    size_d         = req_size[({2'b00, pick} + {pick, 2'b00}) +: 5];
                    mode_d         = mode_cfg[{pick, 1'b0} +: 2];
                    av_write_d     = 1'b1;
                    av_address_d   = ADDR_BRD;
                    av_writedata_d = brd_cfg;
                end
            end
            S_WR_BRD: begin
                av_write_d = 1'b1;
                if (!av_waitrequest) begin
                    state_d        = S_WR_CTRL;
                    av_address_d   = ADDR_CTRL;
                    av_writedata_d = ctrl_word;
                end
            end
            S_WR_CTRL: begin
                av_write_d = 1'b1;
                if (!av_waitrequest) begin
                    state_d        = S_WR_DATA;
                    av_address_d   = ADDR_DATA;
                    av_writedata_d = data_q;
                end
            end
            S_WR_DATA: begin
                av_write_d = 1'b1;
                if (!av_waitrequest) begin
                    state_d      = S_POLL;
                    av_write_d   = 1'b0;
                    av_read_d    = 1'b1;
                    av_address_d = ADDR_STATUS;
                    poll_cnt_d   = '0;
                end
            end
            S_POLL: begin
                av_read_d = 1'b1;
                if (!av_waitrequest) begin
                    poll_cnt_d = poll_inc;
                    // Overflow wins over both the empty flag and the timeout.
                    if (av_readdata[3]) begin
                        state_d        = S_CLR_OV;
                        av_read_d      = 1'b0;
                        av_write_d     = 1'b1;
                        av_address_d   = ADDR_STATUS;
                        av_writedata_d = 32'h0000_0008;
                    end else if (av_readdata[5]) begin
                        state_d    = S_WAIT_CS;
                        av_read_d  = 1'b0;
                        poll_cnt_d = '0;
                        idle_cnt_d = '0;
                    end else if (poll_inc >= TIMEOUT) begin
                        state_d   = S_ERR;
                        av_read_d = 1'b0;
                        err_d     = grant_oh;
                    end
                end
            end
            S_WAIT_CS: begin
                idle_cnt_d = spi_cs_idle ? idle_inc : '0;
                poll_cnt_d = poll_inc;
                if (idle_cnt_d == IDLE_REQ) begin
                    state_d = S_DONE;
                    ack_d   = grant_oh;
                end else if (poll_inc >= TIMEOUT) begin
                    state_d = S_ERR;
                    err_d   = grant_oh;
                end
            end
            S_CLR_OV: begin
                av_write_d = 1'b1;
                if (!av_waitrequest) begin
                    state_d    = S_ERR;
                    av_write_d = 1'b0;
                    err_d      = grant_oh;
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                rr_d    = grant_q + 2'd1;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            grant_q        <= 2'd0;
            rr_q           <= 2'd0;
            data_q         <= 32'h0;
            size_q         <= 5'd0;
            mode_q         <= 2'd0;
            poll_cnt_q     <= '0;
            idle_cnt_q     <= '0;
            av_address_q   <= 2'd0;
            av_write_q     <= 1'b0;
            av_read_q      <= 1'b0;
            av_writedata_q <= 32'h0;
            ack_q          <= 4'b0000;
            err_q          <= 4'b0000;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_q           <= rr_d;
            data_q         <= data_d;
            size_q         <= size_d;
            mode_q         <= mode_d;
            poll_cnt_q     <= poll_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            av_address_q   <= av_address_d;
            av_write_q     <= av_write_d;
            av_read_q      <= av_read_d;
            av_writedata_q <= av_writedata_d;
            ack_q          <= ack_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    assign av_address   = av_address_q;
    assign av_write     = av_write_q;
    assign av_read      = av_read_q;
    assign av_writedata = av_writedata_q;
    assign ack          = ack_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign grant        = grant_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: an Avalon slave model logs every completed command
// and every ack/err pulse, and each scenario compares those logs to hand-computed values.
module tb_spi_txn_arbiter;
    logic         clk, reset;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [19:0]  req_size;
    logic [7:0]   mode_cfg;
    logic [31:0]  brd_cfg;
    logic         spi_cs_idle;
    logic [1:0]   av_address;
    logic         av_write, av_read;
    logic [31:0]  av_writedata, av_readdata;
    logic         av_waitrequest;
    logic [3:0]   ack, err;
    logic         busy;
    logic [1:0]   grant;

    int total_n = 0;
    int bad_n   = 0;
    int ws_cfg  = 0;
    int ws_cnt  = 0;
    int cyc_n   = 0;
    logic [31:0] status_val = 32'h20;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        int          held;
        logic        ok;
        int          t;
    } cmd_t;
    typedef struct {
        logic [3:0] ack;
        logic [3:0] err;
        logic [1:0] gnt;
        int         t;
    } evt_t;
    cmd_t cmdq[$];
    evt_t evq[$];

    spi_txn_arbiter #(.POLL_TIMEOUT(8), .CS_IDLE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_size(req_size),
        .mode_cfg(mode_cfg), .brd_cfg(brd_cfg), .spi_cs_idle(spi_cs_idle),
        .av_address(av_address), .av_write(av_write), .av_read(av_read),
        .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_waitrequest(av_waitrequest), .ack(ack), .err(err), .busy(busy), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign av_waitrequest = (av_write || av_read) && (ws_cnt < ws_cfg);
    assign av_readdata    = status_val;

    // Wait-state counter of the slave model, updated on the active edge.
    initial forever begin
        @(posedge clk);
        cyc_n <= cyc_n + 1;
        if (reset) ws_cnt <= 0;
        else if (av_write || av_read) ws_cnt <= av_waitrequest ? ws_cnt + 1 : 0;
    end

    // Bus and pulse monitor, sampled mid-cycle.
    initial begin
        int          hold_n;
        logic [1:0]  h_addr;
        logic [31:0] h_data;
        logic        h_wr, h_ok;
        cmd_t        c;
        evt_t        e;
        hold_n = 0; h_addr = 0; h_data = 0; h_wr = 0; h_ok = 1;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_n = 0;
            end else if (av_write || av_read) begin
                if (hold_n == 0) begin
                    h_addr = av_address; h_data = av_writedata; h_wr = av_write; h_ok = 1'b1;
                end else if (av_address != h_addr || av_writedata != h_data || av_write != h_wr) begin
                    h_ok = 1'b0;
                end
                hold_n++;
                if (!av_waitrequest) begin
                    c.wr = av_write; c.addr = av_address;
                    c.data = av_write ? av_writedata : av_readdata;
                    c.held = hold_n; c.ok = h_ok && !(av_write && av_read); c.t = cyc_n;
                    cmdq.push_back(c);
                    hold_n = 0;
                end
            end
            if (ack != 4'b0 || err != 4'b0) begin
                e.ack = ack; e.err = err; e.gnt = grant; e.t = cyc_n;
                evq.push_back(e);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_evt(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && evq.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, 64'(evq.size()), 64'(n));
    endtask

    function automatic int count_cmds(input logic wr);
        int n = 0;
        foreach (cmdq[i]) if (cmdq[i].wr == wr) n++;
        return n;
    endfunction

    function automatic logic [63:0] cmd_word(input int i);
        if (i >= cmdq.size()) return 64'hDEAD_DEAD_DEAD_DEAD;
        return 64'({cmdq[i].wr, cmdq[i].addr, cmdq[i].data});
    endfunction

    initial begin
        logic [3:0] oh;
        int         last_rd;
        bit         hit;
        reset = 1'b1; req = 4'b0; req_data = '0; req_size = '0; mode_cfg = '0;
        brd_cfg = 32'd4; spi_cs_idle = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({av_write, av_read, av_address, ack, err, busy, grant}), 64'(0));
        chk("rst_wdata", 64'(av_writedata), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single request on device 0.
        req_data[31:0] = 32'hCE; req_size[4:0] = 5'd7; status_val = 32'h20;
        req = 4'b0001;
        wait_evt("t1_evt", 1, 200);
        req = 4'b0000;
        chk("t1_ncmd", 64'(cmdq.size()), 64'(4));
        chk("t1_brd",  cmd_word(0), 64'({1'b1, 2'd3, 32'd4}));
        chk("t1_ctrl", cmd_word(1), 64'({1'b1, 2'd2, 32'h0000_8027}));
        chk("t1_data", cmd_word(2), 64'({1'b1, 2'd0, 32'hCE}));
        chk("t1_poll", cmd_word(3), 64'({1'b0, 2'd1, 32'h20}));
        if (cmdq.size() >= 4 && evq.size() >= 1) begin
            chk("t1_poll_lat", 64'(cmdq[3].t - cmdq[0].t), 64'(3));
            chk("t1_ack_lat", 64'(evq[0].t - cmdq[3].t), 64'(3));
            chk("t1_pulse", 64'({evq[0].ack, evq[0].err, evq[0].gnt}), 64'({4'b0001, 4'b0000, 2'd0}));
        end
        repeat (3) @(negedge clk);
        chk("t1_busy", 64'(busy), 64'(0));
        chk("t1_once", 64'(evq.size()), 64'(1));

        // Round robin from a fresh pointer with all requests held.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmdq.delete(); evq.delete();
        req = 4'b1111;
        wait_evt("t2_evt", 5, 400);
        req = 4'b0000;
        for (int k = 0; k < 5 && k < evq.size(); k++) begin
            oh = 4'b0001 << (k % 4);
            chk($sformatf("t2_rr%0d", k), 64'({evq[k].gnt, evq[k].ack, evq[k].err}),
                64'({2'(k % 4), oh, 4'b0000}));
        end
        repeat (2) @(negedge clk);

        // Three wait states on every command, device 1 in mode 3.
        cmdq.delete(); evq.delete();
        ws_cfg = 3;
        req_data[63:32] = 32'h1234_5678; req_size[9:5] = 5'd15; mode_cfg[3:2] = 2'b11;
        req = 4'b0010;
        wait_evt("t3_evt", 1, 300);
        req = 4'b0000; ws_cfg = 0;
        chk("t3_nwr", 64'(count_cmds(1'b1)), 64'(3));
        chk("t3_brd",  cmd_word(0), 64'({1'b1, 2'd3, 32'd4}));
        chk("t3_ctrl", cmd_word(1), 64'({1'b1, 2'd2, 32'h0003_A04F}));
        chk("t3_data", cmd_word(2), 64'({1'b1, 2'd0, 32'h1234_5678}));
        for (int k = 0; k < 4 && k < cmdq.size(); k++)
            chk($sformatf("t3_hold%0d", k), 64'({cmdq[k].held, cmdq[k].ok}), 64'({32'd4, 1'b1}));
        if (evq.size() >= 1) chk("t3_ack", 64'({evq[0].ack, evq[0].err}), 64'({4'b0010, 4'b0000}));
        repeat (2) @(negedge clk);

        // Overflow on device 2, then device 3 is served normally.
        cmdq.delete(); evq.delete();
        status_val = 32'h08;
        req = 4'b1100;
        wait_evt("t4_evt1", 1, 200);
        req = 4'b1000; status_val = 32'h20;
        wait_evt("t4_evt2", 2, 200);
        req = 4'b0000;
        chk("t4_poll", cmd_word(3), 64'({1'b0, 2'd1, 32'h08}));
        chk("t4_clr",  cmd_word(4), 64'({1'b1, 2'd1, 32'h08}));
        chk("t4_next", cmd_word(5), 64'({1'b1, 2'd3, 32'd4}));
        if (evq.size() >= 2) begin
            chk("t4_err", 64'({evq[0].gnt, evq[0].ack, evq[0].err}), 64'({2'd2, 4'b0000, 4'b0100}));
            chk("t4_ack", 64'({evq[1].gnt, evq[1].ack, evq[1].err}), 64'({2'd3, 4'b1000, 4'b0000}));
        end
        repeat (2) @(negedge clk);

        // STATUS never reports empty: eight reads then an error.
        cmdq.delete(); evq.delete();
        status_val = 32'h00;
        req = 4'b0001;
        wait_evt("t5_evt", 1, 200);
        req = 4'b0000;
        chk("t5_reads", 64'(count_cmds(1'b0)), 64'(8));
        last_rd = cmdq.size() - 1;
        if (evq.size() >= 1 && last_rd >= 0) begin
            chk("t5_err", 64'({evq[0].ack, evq[0].err}), 64'({4'b0000, 4'b0001}));
            chk("t5_lat", 64'(evq[0].t - cmdq[last_rd].t), 64'(1));
        end
        repeat (2) @(negedge clk);

        // Chip select never idles: abort after eight cycles of waiting.
        cmdq.delete(); evq.delete();
        status_val = 32'h20; spi_cs_idle = 1'b0;
        req = 4'b0010;
        wait_evt("t6_evt", 1, 200);
        req = 4'b0000; spi_cs_idle = 1'b1;
        chk("t6_reads", 64'(count_cmds(1'b0)), 64'(1));
        if (evq.size() >= 1 && cmdq.size() >= 4) begin
            chk("t6_err", 64'({evq[0].ack, evq[0].err}), 64'({4'b0000, 4'b0010}));
            chk("t6_lat", 64'(evq[0].t - cmdq[3].t), 64'(9));
        end
        repeat (2) @(negedge clk);

        // Reset while the DATA write is stalled.
        cmdq.delete(); evq.delete();
        ws_cfg = 10;
        req = 4'b0001;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (av_write && av_address == 2'd0) hit = 1'b1;
        end
        chk("t7_reach", 64'(hit), 64'(1));
        reset = 1'b1;
        #1;
        chk("t7_async", 64'({av_write, av_read, busy, grant}), 64'(0));
        req = 4'b0100; ws_cfg = 0;
        repeat (2) @(negedge clk);
        chk("t7_noevt", 64'(evq.size()), 64'(0));
        reset = 1'b0;
        cmdq.delete();
        wait_evt("t7_evt", 1, 200);
        req = 4'b0000;
        chk("t7_first", cmd_word(0), 64'({1'b1, 2'd3, 32'd4}));
        if (evq.size() >= 1)
            chk("t7_ack", 64'({evq[0].gnt, evq[0].ack, evq[0].err}), 64'({2'd2, 4'b0100, 4'b0000}));

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
